uart_tx_byte: RTL

Single-byte UART transmitter: 8N1 framing, LSB first, fixed baud derived from the system clock.
Sits directly downstream of the multi-byte sequencer. It consumes that block's uart_en/uart_din pair and returns uart_tx_busy. The sequencer advances its byte counter on each falling edge of uart_tx_busy, so busy must rise and fall exactly once per accepted byte.
Drives the GPSDO serial TX pin.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_byte_if.sv | 21 ++
 rtl/uart_baud_cnt.sv | 36 +++
 rtl/uart_tx_byte.sv | 123 ++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, baud divisor helpers and frame length.
// Used by the TX byte block and intended for reuse by the RX block.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // start + 8 data + stop
    localparam int FRAME_BITS = 10;

    function automatic int calc_bps_cnt(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

    function automatic int calc_cnt_w(input int clk_freq, input int uart_bps);
        int n;
        n = calc_bps_cnt(clk_freq, uart_bps);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_byte_if.sv
// Request/serial-line bundle between the byte sequencer and the UART transmitter.
interface uart_tx_byte_if;
    logic       uart_en;
    logic [7:0] uart_din;
    logic       uart_tx_busy;
    logic       uart_txd;

    modport master (
        output uart_en,
        output uart_din,
        input  uart_tx_busy,
        input  uart_txd
    );

    modport slave (
        input  uart_en,
        input  uart_din,
        output uart_tx_busy,
        output uart_txd
    );
endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..BPS_CNT-1, ticks on the last count, synchronous clear.
module uart_baud_cnt #(
    parameter int BPS_CNT = 10,
    parameter int CNT_W   = 4
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BPS_CNT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 UART transmitter, LSB first; one frame per rising edge of uart_en.
// busy and txd are registered so the pin has no combinational path.
module uart_tx_byte #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 115200
) (
    input  logic           CLK_SYS,
    input  logic           CLK_RST,
    uart_tx_byte_if.slave  tx_if
);
    import uart_pkg::*;

    localparam int BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);
    localparam int CNT_W   = calc_cnt_w(CLK_FREQ, UART_BPS);

    generate
        if (BPS_CNT < 2) begin : g_bad_bps
            $error("uart_tx_byte: CLK_FREQ/UART_BPS must be at least 2");
        end
    endgenerate

    logic        en_d0_q;
    logic        en_d1_q;
    logic        en_flag;
    uart_state_e state_q,   state_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [2:0]  bit_nxt;
    logic [7:0]  shift_q,   shift_d;
    logic        busy_q,    busy_d;
    logic        txd_q,     txd_d;
    logic        baud_clr;
    logic        baud_tick;

    assign en_flag  = en_d0_q & ~en_d1_q;
    // Holding the counter at zero in IDLE means it starts fresh on START entry.
    assign baud_clr = (state_q == ST_IDLE);
    assign bit_nxt  = bit_idx_q + 3'd1;

    uart_baud_cnt #(
        .BPS_CNT (BPS_CNT),
        .CNT_W   (CNT_W)
    ) u_baud_cnt (
        .clk_sys (CLK_SYS),
        .rst_n   (CLK_RST),
        .clr     (baud_clr),
        .tick    (baud_tick)
    );

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        busy_d    = busy_q;
        txd_d     = txd_q;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                txd_d  = 1'b1;
                if (en_flag) begin
                    shift_d   = tx_if.uart_din;
                    bit_idx_d = 3'd0;
                    state_d   = ST_START;
                    busy_d    = 1'b1;
                    txd_d     = 1'b0;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                    txd_d     = shift_q[0];
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    bit_idx_d = bit_nxt;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        txd_d   = shift_q[bit_nxt];
                    end
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    txd_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            en_d0_q   <= 1'b0;
            en_d1_q   <= 1'b0;
            state_q   <= ST_IDLE;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            busy_q    <= 1'b0;
            txd_q     <= 1'b1;
        end else begin
            en_d0_q   <= tx_if.uart_en;
            en_d1_q   <= en_d0_q;
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            busy_q    <= busy_d;
            txd_q     <= txd_d;
        end
    end

    assign tx_if.uart_tx_busy = busy_q;
    assign tx_if.uart_txd     = txd_q;

endmodule
